// File: rtl/click_fork_n.sv
// click_fork_n: 2-phase click-style fork that copies one input token to a selected subset of N_OUT branches
//   Parameters: WIDTH (payload bits), N_OUT (branches, 2..8), PHASE_INIT (reset phase of all handshakes)
//   clk, rst_n      : clock and synchronous active-low reset
//   in_req/in_ack   : input 2-phase handshake; a token is pending while they differ
//   in_data/in_sel  : token payload and branch select mask, sampled on acceptance
//   out_req/out_ack : per-branch 2-phase handshakes; out_req toggles only on selected branches
//   out_data        : payload of the last accepted token, shared by all branches
//   busy            : high while waiting for the selected branches to acknowledge
//   tok_cnt         : free-running count of completed tokens, wraps at 16 bits
//   Build option CLICK_FORK_SYNC_EN: 2-flop synchronizers on in_req and out_ack
module click_fork_n #(
   parameter int WIDTH = 8,
   parameter int N_OUT = 2,
   parameter bit PHASE_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_req,
   output logic             in_ack,
   input  logic [WIDTH-1:0] in_data,
   input  logic [N_OUT-1:0] in_sel,
   output logic [N_OUT-1:0] out_req,
   input  logic [N_OUT-1:0] out_ack,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic [15:0]      tok_cnt
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t           state;
   logic [N_OUT-1:0] sel_q;
   logic             req_s;
   logic [N_OUT-1:0] ack_s;
`ifdef CLICK_FORK_SYNC_EN
   logic [1:0]       req_ff;
   logic [N_OUT-1:0] ack_ff0, ack_ff1;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_ff  <= {2{PHASE_INIT}};
         ack_ff0 <= {N_OUT{PHASE_INIT}};
         ack_ff1 <= {N_OUT{PHASE_INIT}};
      end else begin
         req_ff  <= {req_ff[0], in_req};
         ack_ff0 <= out_ack;
         ack_ff1 <= ack_ff0;
      end
   end
   assign req_s = req_ff[1];
   assign ack_s = ack_ff1;
`else
   assign req_s = in_req;
   assign ack_s = out_ack;
`endif
   assign busy = (state == WAIT);
   // Completion is checked only from the second WAIT edge on, so an empty or pre-matched
   // selection still spends exactly one cycle in WAIT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         in_ack   <= PHASE_INIT;
         out_req  <= {N_OUT{PHASE_INIT}};
         out_data <= '0;
         sel_q    <= '0;
         tok_cnt  <= '0;
      end else if (state == IDLE) begin
         if (req_s != in_ack) begin
            out_data <= in_data;
            sel_q    <= in_sel;
            out_req  <= out_req ^ in_sel;
            state    <= WAIT;
         end
      end else if (((ack_s ^ out_req) & sel_q) == '0) begin
         in_ack  <= ~in_ack;
         tok_cnt <= tok_cnt + 16'd1;
         state   <= IDLE;
      end
   end
endmodule

// File: tb/tb_click_fork_n.sv
// tb_click_fork_n: self-checking bench for click_fork_n with a token-level model and directed vectors
module tb_click_fork_n;
`ifdef CLICK_FORK_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif
   logic       clk, rst_n;
   logic       in_req, in_ack, busy;
   logic [7:0] in_data, out_data;
   logic [3:0] in_sel, out_req, out_ack;
   logic [15:0] tok_cnt;
   logic       r2, ia2, b2;
   logic [7:0] d2, od2;
   logic [1:0] s2, o2, a2;
   logic [15:0] c2;
   int         errs = 0, checks = 0, lat;
   bit         cmp_en;

   click_fork_n #(.WIDTH(8), .N_OUT(4), .PHASE_INIT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
      .in_sel(in_sel), .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
      .busy(busy), .tok_cnt(tok_cnt));

   click_fork_n dut2 (
      .clk(clk), .rst_n(rst_n), .in_req(r2), .in_ack(ia2), .in_data(d2),
      .in_sel(s2), .out_req(o2), .out_ack(a2), .out_data(od2),
      .busy(b2), .tok_cnt(c2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Token-level model: delayed views of the handshake inputs, one token in flight,
   // completion when no selected branch still has an outstanding acknowledge.
   logic       h_req [3];
   logic [3:0] h_ack [3];
   bit         m_busy;
   logic       m_ack;
   logic [3:0] m_req, m_sel;
   logic [7:0] m_data;
   int         m_cnt;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            h_req[i] = 1'b0;
            h_ack[i] = 4'b0;
         end
         m_busy = 0; m_ack = 1'b0; m_req = 4'b0; m_sel = 4'b0; m_data = 8'h00; m_cnt = 0;
      end else begin
         h_req[2] = h_req[1]; h_req[1] = h_req[0]; h_req[0] = in_req;
         h_ack[2] = h_ack[1]; h_ack[1] = h_ack[0]; h_ack[0] = out_ack;
         if (!m_busy) begin
            if (h_req[SL] != m_ack) begin
               m_busy = 1; m_data = in_data; m_sel = in_sel; m_req = m_req ^ in_sel;
            end
         end else if ($countones((h_ack[SL] ^ m_req) & m_sel) == 0) begin
            m_busy = 0; m_ack = ~m_ack; m_cnt = (m_cnt + 1) % 65536;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp_in_ack", in_ack, m_ack);
         chk("cmp_out_req", out_req, m_req);
         chk("cmp_out_data", out_data, m_data);
         chk("cmp_busy", busy, m_busy);
         chk("cmp_tok_cnt", tok_cnt, m_cnt);
      end
   end

   initial begin
      rst_n = 0; in_req = 0; in_data = 0; in_sel = 0; out_ack = 0;
      r2 = 0; d2 = 0; s2 = 0; a2 = 0; cmp_en = 0;
      repeat (2) @(negedge clk);
      cmp_en = 1;
      chk("rst_in_ack", in_ack, 0);
      chk("rst_out_req", out_req, 4'b0000);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_tok", tok_cnt, 16'd0);
      chk("n2_rst_tok", c2, 16'd0);
      rst_n = 1;
      // two-branch instance: broadcast token
      d2 = 8'hA5; s2 = 2'b11; r2 = 1;
      repeat (1 + SL) @(negedge clk);
      chk("n2_out_req", o2, 2'b11);
      chk("n2_out_data", od2, 8'hA5);
      a2 = 2'b11;
      repeat (1 + SL) @(negedge clk);
      chk("n2_in_ack", ia2, 1);
      chk("n2_tok", c2, 16'd1);
      // sparse select, stray ack on an unselected branch, out-of-order completion
      in_data = 8'h3C; in_sel = 4'b0101; in_req = 1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (out_req == 4'b0000 && lat < 20);
      chk("a_req_lat", lat, 1 + SL);
      chk("a_out_req", out_req, 4'b0101);
      chk("a_out_data", out_data, 8'h3C);
      out_ack = 4'b0010; in_data = 8'hFF; in_sel = 4'b1111;
      repeat (4) @(negedge clk);
      chk("a_ign_ack1", in_ack, 0);
      chk("a_ign_data", out_data, 8'h3C);
      chk("a_busy", busy, 1);
      out_ack = 4'b0011;
      repeat (4) @(negedge clk);
      chk("a_part_ack", in_ack, 0);
      out_ack = 4'b0111;
      lat = 0;
      do begin @(negedge clk); lat++; end while (in_ack == 1'b0 && lat < 20);
      chk("a_done_lat", lat, 1 + SL);
      chk("a_tok", tok_cnt, 16'd1);
      // empty select: token dropped after a single WAIT cycle
      in_sel = 4'b0000; in_data = 8'h77; in_req = 0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (in_ack == 1'b1 && lat < 20);
      chk("b_lat", lat, 2 + SL);
      chk("b_out_req", out_req, 4'b0101);
      chk("b_tok", tok_cnt, 16'd2);
      // ack already matching on entry still costs one WAIT cycle
      out_ack = 4'b1111; in_sel = 4'b1000; in_data = 8'hE1; in_req = 1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (in_ack == 1'b0 && lat < 20);
      chk("c_lat", lat, 2 + SL);
      chk("c_out_req", out_req, 4'b1101);
      chk("c_tok", tok_cnt, 16'd3);
      // reset while waiting abandons the token
      in_sel = 4'b0001; in_data = 8'h5A; in_req = 0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (busy != 1'b1 && lat < 20);
      chk("d_busy", busy, 1);
      chk("d_out_req", out_req, 4'b1100);
      rst_n = 0;
      @(negedge clk);
      chk("d_rst_in_ack", in_ack, 0);
      chk("d_rst_out_req", out_req, 4'b0000);
      chk("d_rst_out_data", out_data, 8'h00);
      chk("d_rst_tok", tok_cnt, 16'd0);
      chk("d_rst_busy", busy, 0);
      rst_n = 1; out_ack = 4'b1110;
      repeat (6) @(negedge clk);
      chk("d_late_ack", in_ack, 0);
      chk("d_late_tok", tok_cnt, 16'd0);
      out_ack = 4'b0000;
      @(negedge clk);
      // full counter lap
      in_sel = 4'b0000;
      for (int i = 0; i < 65536; i++) begin
         in_req = ~in_req;
         lat = 0;
         do begin @(negedge clk); lat++; end while (in_ack != in_req && lat < 20);
         if (in_ack != in_req) begin
            chk("e_timeout", in_ack, in_req);
            break;
         end
         if (i == 65534) chk("e_ffff", tok_cnt, 16'hFFFF);
      end
      chk("e_wrap", tok_cnt, 16'h0000);
      chk("e_parity", in_ack, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
